// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, datapath defaults and the forwarding-source enum.
package cpu_pkg;

  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 5;
  localparam int unsigned DEF_IMM_W  = 16;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd8;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EXM,
    FWD_WB
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-ID/EX bundle: valid/ready handshake plus the decoded instruction fields.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = cpu_pkg::DEF_DATA_W,
  parameter int unsigned REG_AW = cpu_pkg::DEF_REG_AW,
  parameter int unsigned IMM_W  = cpu_pkg::DEF_IMM_W
) ();

  logic                          id_valid;
  logic                          id_ready;
  logic [cpu_pkg::ALU_OP_W-1:0]  id_alu_op;
  logic [DATA_W-1:0]             id_rs_val;
  logic [DATA_W-1:0]             id_rt_val;
  logic [REG_AW-1:0]             id_rs_addr;
  logic [REG_AW-1:0]             id_rt_addr;
  logic [REG_AW-1:0]             id_rd_addr;
  logic                          id_reg_write;
  logic [IMM_W-1:0]              id_imm;
  logic                          id_imm_sext;
  logic                          id_alu_src;
  logic [4:0]                    id_shamt;

  modport master (
    output id_valid, id_alu_op, id_rs_val, id_rt_val, id_rs_addr, id_rt_addr,
           id_rd_addr, id_reg_write, id_imm, id_imm_sext, id_alu_src, id_shamt,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_alu_op, id_rs_val, id_rt_val, id_rs_addr, id_rt_addr,
           id_rd_addr, id_reg_write, id_imm, id_imm_sext, id_alu_src, id_shamt,
    output id_ready
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Forwarding mux: picks EX/MEM, then MEM/WB, then the base value; register 0 never forwards.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] rf_val,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_value,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_value,
  output logic [DATA_W-1:0] val
);

  fwd_sel_e sel;
  logic     addr_live;

  always_comb begin
    addr_live = (addr != REG_AW'(REG_ZERO));
    sel       = FWD_RF;
    if (addr_live && exm_reg_write && (exm_rd == addr)) begin
      sel = FWD_EXM;
    end else if (addr_live && wb_reg_write && (wb_rd == addr)) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    case (sel)
      FWD_EXM: val = exm_value;
      FWD_WB:  val = wb_value;
      default: val = rf_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with valid/ready handshake, flush and stall.
// Define FWD_EN to enable EX/MEM and MEM/WB forwarding plus operand snooping while stalled.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW,
  parameter int unsigned IMM_W  = DEF_IMM_W
) (
  input  logic                clk,
  input  logic                rst_n,
  id_ex_stage_if.slave        id,
  input  logic                exm_reg_write,
  input  logic [REG_AW-1:0]   exm_rd,
  input  logic [DATA_W-1:0]   exm_value,
  input  logic                wb_reg_write,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic [DATA_W-1:0]   wb_value,
  input  logic                flush,
  input  logic                ex_ready,
  output logic                ex_valid,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [DATA_W-1:0]   crs,
  output logic [DATA_W-1:0]   alu_in,
  output logic [4:0]          shamt,
  output logic [DATA_W-1:0]   ex_rt_val,
  output logic [REG_AW-1:0]   ex_rd,
  output logic                ex_reg_write
);

  logic                ex_valid_q, ex_valid_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   crs_q, crs_d;
  logic [DATA_W-1:0]   alu_in_q, alu_in_d;
  logic [4:0]          shamt_q, shamt_d;
  logic [DATA_W-1:0]   ex_rt_val_q, ex_rt_val_d;
  logic [REG_AW-1:0]   ex_rd_q, ex_rd_d;
  logic                ex_reg_write_q, ex_reg_write_d;
  logic [REG_AW-1:0]   rs_addr_q, rs_addr_d;
  logic [REG_AW-1:0]   rt_addr_q, rt_addr_d;
  logic                alu_src_q, alu_src_d;

  logic              accept;
  logic              stall;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  assign id.id_ready = !ex_valid_q || ex_ready;
  assign accept      = id.id_valid && id.id_ready && !flush;
  assign stall       = ex_valid_q && !ex_ready;
  assign imm_ext     = id.id_imm_sext ? {{(DATA_W-IMM_W){id.id_imm[IMM_W-1]}}, id.id_imm}
                                      : {{(DATA_W-IMM_W){1'b0}}, id.id_imm};

`ifdef FWD_EN
  // While stalled the muxes re-forward the held operands using the stored addresses.
  logic [REG_AW-1:0] rs_sel_addr, rt_sel_addr;
  logic [DATA_W-1:0] rs_base, rt_base;

  assign rs_sel_addr = stall ? rs_addr_q   : id.id_rs_addr;
  assign rt_sel_addr = stall ? rt_addr_q   : id.id_rt_addr;
  assign rs_base     = stall ? crs_q       : id.id_rs_val;
  assign rt_base     = stall ? ex_rt_val_q : id.id_rt_val;

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .addr          (rs_sel_addr),
    .rf_val        (rs_base),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_value     (exm_value),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_value      (wb_value),
    .val           (rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .addr          (rt_sel_addr),
    .rf_val        (rt_base),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_value     (exm_value),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_value      (wb_value),
    .val           (rt_fwd)
  );
`else
  logic unused_fwd;

  assign rs_fwd     = id.id_rs_val;
  assign rt_fwd     = id.id_rt_val;
  assign unused_fwd = ^{exm_reg_write, exm_rd, exm_value, wb_reg_write, wb_rd, wb_value,
                        rs_addr_q, rt_addr_q, alu_src_q};
`endif

  always_comb begin
    ex_valid_d     = ex_valid_q;
    alu_op_d       = alu_op_q;
    crs_d          = crs_q;
    alu_in_d       = alu_in_q;
    shamt_d        = shamt_q;
    ex_rt_val_d    = ex_rt_val_q;
    ex_rd_d        = ex_rd_q;
    ex_reg_write_d = ex_reg_write_q;
    rs_addr_d      = rs_addr_q;
    rt_addr_d      = rt_addr_q;
    alu_src_d      = alu_src_q;

    if (flush) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
    end else if (accept) begin
      ex_valid_d     = 1'b1;
      alu_op_d       = id.id_alu_op;
      crs_d          = rs_fwd;
      ex_rt_val_d    = rt_fwd;
      alu_in_d       = id.id_alu_src ? imm_ext : rt_fwd;
      shamt_d        = id.id_shamt;
      ex_rd_d        = id.id_rd_addr;
      ex_reg_write_d = id.id_reg_write;
      rs_addr_d      = id.id_rs_addr;
      rt_addr_d      = id.id_rt_addr;
      alu_src_d      = id.id_alu_src;
    end else if (stall) begin
`ifdef FWD_EN
      crs_d       = rs_fwd;
      ex_rt_val_d = rt_fwd;
      if (!alu_src_q) begin
        alu_in_d = rt_fwd;
      end
`endif
    end else if (ex_valid_q && ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      alu_op_q       <= '0;
      crs_q          <= '0;
      alu_in_q       <= '0;
      shamt_q        <= '0;
      ex_rt_val_q    <= '0;
      ex_rd_q        <= '0;
      ex_reg_write_q <= 1'b0;
      rs_addr_q      <= '0;
      rt_addr_q      <= '0;
      alu_src_q      <= 1'b0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      alu_op_q       <= alu_op_d;
      crs_q          <= crs_d;
      alu_in_q       <= alu_in_d;
      shamt_q        <= shamt_d;
      ex_rt_val_q    <= ex_rt_val_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      rs_addr_q      <= rs_addr_d;
      rt_addr_q      <= rt_addr_d;
      alu_src_q      <= alu_src_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign alu_op       = alu_op_q;
  assign crs          = crs_q;
  assign alu_in       = alu_in_q;
  assign shamt        = shamt_q;
  assign ex_rt_val    = ex_rt_val_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_write = ex_reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations plus random traffic
// compared each cycle against a behavioural model of the held instruction.
module tb_id_ex_stage;

`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exm_reg_write, wb_reg_write, flush, ex_ready;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_value, wb_value;
  logic        ex_valid, ex_reg_write;
  logic [3:0]  alu_op;
  logic [31:0] crs, alu_in, ex_rt_val;
  logic [4:0]  shamt, ex_rd;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .IMM_W(16)) idi ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .IMM_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id            (idi),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_value     (exm_value),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_value      (wb_value),
    .flush         (flush),
    .ex_ready      (ex_ready),
    .ex_valid      (ex_valid),
    .alu_op        (alu_op),
    .crs           (crs),
    .alu_in        (alu_in),
    .shamt         (shamt),
    .ex_rt_val     (ex_rt_val),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: the instruction currently held by the stage, as seen by EX.
  logic        m_valid, m_rw, m_src;
  logic [3:0]  m_op;
  logic [31:0] m_crs, m_alu, m_rt;
  logic [4:0]  m_sh, m_rd, m_rsa, m_rta;

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] base);
    if (FWD && a != 5'd0 && exm_reg_write && exm_rd == a) return exm_value;
    if (FWD && a != 5'd0 && wb_reg_write && wb_rd == a) return wb_value;
    return base;
  endfunction

  function automatic logic [31:0] ext(input logic [15:0] imm, input logic sx);
    if (sx) return 32'($signed(imm));
    return 32'(imm);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_rw <= 1'b0; m_src <= 1'b0; m_op <= '0;
      m_crs <= '0; m_alu <= '0; m_rt <= '0; m_sh <= '0; m_rd <= '0;
      m_rsa <= '0; m_rta <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_rw    <= 1'b0;
    end else if (idi.id_valid && (!m_valid || ex_ready)) begin
      m_valid <= 1'b1;
      m_rw    <= idi.id_reg_write;
      m_src   <= idi.id_alu_src;
      m_op    <= idi.id_alu_op;
      m_crs   <= fwd(idi.id_rs_addr, idi.id_rs_val);
      m_rt    <= fwd(idi.id_rt_addr, idi.id_rt_val);
      m_alu   <= idi.id_alu_src ? ext(idi.id_imm, idi.id_imm_sext)
                                : fwd(idi.id_rt_addr, idi.id_rt_val);
      m_sh    <= idi.id_shamt;
      m_rd    <= idi.id_rd_addr;
      m_rsa   <= idi.id_rs_addr;
      m_rta   <= idi.id_rt_addr;
    end else if (m_valid && !ex_ready) begin
      m_crs <= fwd(m_rsa, m_crs);
      m_rt  <= fwd(m_rta, m_rt);
      if (!m_src) m_alu <= fwd(m_rta, m_rt);
    end else begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_ex_valid", 32'(ex_valid), 32'(m_valid));
      chk("m_ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
      chk("m_id_ready", 32'(idi.id_ready), 32'(!m_valid || ex_ready));
      if (m_valid) begin
        chk("m_alu_op", 32'(alu_op), 32'(m_op));
        chk("m_crs", crs, m_crs);
        chk("m_alu_in", alu_in, m_alu);
        chk("m_shamt", 32'(shamt), 32'(m_sh));
        chk("m_ex_rt_val", ex_rt_val, m_rt);
        chk("m_ex_rd", 32'(ex_rd), 32'(m_rd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] op, input logic [31:0] rsv, input logic [31:0] rtv,
                       input logic [4:0] rsa, input logic [4:0] rta, input logic [4:0] rd,
                       input logic rw, input logic [15:0] imm, input logic sx,
                       input logic src, input logic [4:0] sh);
    idi.id_valid     = 1'b1;
    idi.id_alu_op    = op;
    idi.id_rs_val    = rsv;
    idi.id_rt_val    = rtv;
    idi.id_rs_addr   = rsa;
    idi.id_rt_addr   = rta;
    idi.id_rd_addr   = rd;
    idi.id_reg_write = rw;
    idi.id_imm       = imm;
    idi.id_imm_sext  = sx;
    idi.id_alu_src   = src;
    idi.id_shamt     = sh;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, "_ex_reg_write"}, 32'(ex_reg_write), 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({tag, "_crs"}, crs, 32'd0);
    chk({tag, "_alu_in"}, alu_in, 32'd0);
    chk({tag, "_shamt"}, 32'(shamt), 32'd0);
    chk({tag, "_ex_rt_val"}, ex_rt_val, 32'd0);
    chk({tag, "_ex_rd"}, 32'(ex_rd), 32'd0);
  endtask

  initial begin
    offer(4'd0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    idi.id_valid  = 1'b0;
    exm_reg_write = 1'b0; exm_rd = '0; exm_value = '0;
    wb_reg_write  = 1'b0; wb_rd  = '0; wb_value  = '0;
    flush = 1'b0; ex_ready = 1'b1;

    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic capture, 1-cycle latency
    offer(4'd2, 32'd5, 32'd7, 5'd1, 5'd2, 5'd6, 1'b1, 16'h0, 1'b0, 1'b0, 5'd3);
    tick(); idi.id_valid = 1'b0;
    @(negedge clk);
    chk("t1_ex_valid", 32'(ex_valid), 32'd1);
    chk("t1_crs", crs, 32'd5);
    chk("t1_alu_in", alu_in, 32'd7);
    chk("t1_id_ready", 32'(idi.id_ready), 32'd1);
    chk("t1_alu_op", 32'(alu_op), 32'd2);

    // Forward priority and register-0 exclusion
    exm_reg_write = 1'b1; exm_rd = 5'd3; exm_value = 32'hAA;
    wb_reg_write  = 1'b1; wb_rd  = 5'd3; wb_value  = 32'hBB;
    offer(4'd0, 32'h11, 32'h22, 5'd3, 5'd5, 5'd1, 1'b0, 16'h0, 1'b0, 1'b0, 5'd0);
    tick(); idi.id_valid = 1'b0;
    @(negedge clk);
    chk("t2_exm", crs, FWD ? 32'hAA : 32'h11);
    exm_reg_write = 1'b0;
    offer(4'd0, 32'h11, 32'h22, 5'd3, 5'd5, 5'd1, 1'b0, 16'h0, 1'b0, 1'b0, 5'd0);
    tick(); idi.id_valid = 1'b0;
    @(negedge clk);
    chk("t2_wb", crs, FWD ? 32'hBB : 32'h11);
    exm_reg_write = 1'b1; exm_rd = 5'd0; wb_rd = 5'd0;
    offer(4'd0, 32'h11, 32'h22, 5'd0, 5'd5, 5'd1, 1'b0, 16'h0, 1'b0, 1'b0, 5'd0);
    tick(); idi.id_valid = 1'b0;
    @(negedge clk);
    chk("t2_r0", crs, 32'h11);
    exm_reg_write = 1'b0; wb_reg_write = 1'b0;

    // Immediate extension
    offer(4'd0, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3, 1'b1, 16'h8000, 1'b1, 1'b1, 5'd0);
    tick(); idi.id_valid = 1'b0;
    @(negedge clk);
    chk("t3_sext", alu_in, 32'hFFFF8000);
    offer(4'd0, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3, 1'b1, 16'h8000, 1'b0, 1'b1, 5'd0);
    tick(); idi.id_valid = 1'b0;
    @(negedge clk);
    chk("t3_zext", alu_in, 32'h00008000);

    // Stall with a producer retiring mid-stall
    offer(4'd1, 32'h66, 32'h55, 5'd6, 5'd4, 5'd2, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0);
    tick(); idi.id_valid = 1'b0; ex_ready = 1'b0;
    @(negedge clk);
    chk("t4_ready_c1", 32'(idi.id_ready), 32'd0);
    tick(); wb_reg_write = 1'b1; wb_rd = 5'd4; wb_value = 32'h1234;
    @(negedge clk);
    chk("t4_ready_c2", 32'(idi.id_ready), 32'd0);
    tick(); wb_reg_write = 1'b0;
    @(negedge clk);
    chk("t4_alu_in", alu_in, FWD ? 32'h1234 : 32'h55);
    chk("t4_rt_val", ex_rt_val, FWD ? 32'h1234 : 32'h55);
    chk("t4_ready_c3", 32'(idi.id_ready), 32'd0);
    tick(); ex_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_held", 32'(ex_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("t4_valid_drop", 32'(ex_valid), 32'd0);

    // Flush beats stall and a same-cycle offer
    offer(4'd3, 32'h1, 32'h2, 5'd1, 5'd2, 5'd8, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0);
    tick(); idi.id_valid = 1'b0; ex_ready = 1'b0;
    tick();
    flush = 1'b1;
    offer(4'd4, 32'h3, 32'h4, 5'd1, 5'd2, 5'd9, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0);
    tick(); flush = 1'b0; idi.id_valid = 1'b0;
    @(negedge clk);
    chk("t5_ex_valid", 32'(ex_valid), 32'd0);
    chk("t5_reg_write", 32'(ex_reg_write), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_not_captured", 32'(ex_valid), 32'd0);
    ex_ready = 1'b1;

    // Asynchronous reset while stalled
    offer(4'd5, 32'h33, 32'h44, 5'd1, 5'd2, 5'd7, 1'b1, 16'h0, 1'b0, 1'b0, 5'd9);
    tick(); idi.id_valid = 1'b0; ex_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t6");
    @(posedge clk); #1 rst_n = 1'b1; ex_ready = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      offer(4'($urandom_range(0, 8)), $urandom, $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
      idi.id_valid  = ($urandom_range(0, 3) != 0);
      exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(0, 7)); exm_value = $urandom;
      wb_reg_write  = 1'($urandom); wb_rd  = 5'($urandom_range(0, 7)); wb_value  = $urandom;
      flush    = ($urandom_range(0, 15) == 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Captures decoded operands, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and selects the second ALU operand between the immediate and rt.
- Drives the ALU's alu_op, alu_in, crs and shamt from registers.
- Valid/ready handshake toward decode; stall input from EX.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-file address width
IMM_W, 16, raw immediate width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode holds an instruction
id_ready  out  1  stage can accept this cycle
id_alu_op  in  4  ALU operation code
id_rs_val  in  DATA_W  register-file rs read value
id_rt_val  in  DATA_W  register-file rt read value
id_rs_addr  in  REG_AW  rs index
id_rt_addr  in  REG_AW  rt index
id_rd_addr  in  REG_AW  destination index
id_reg_write  in  1  instruction writes rd
id_imm  in  IMM_W  raw immediate
id_imm_sext  in  1  1 = sign-extend immediate, 0 = zero-extend
id_alu_src  in  1  1 = immediate operand, 0 = rt operand
id_shamt  in  5  shift amount
exm_reg_write  in  1  EX/MEM writes a register
exm_rd  in  REG_AW  EX/MEM destination
exm_value  in  DATA_W  EX/MEM result
wb_reg_write  in  1  MEM/WB writes a register
wb_rd  in  REG_AW  MEM/WB destination
wb_value  in  DATA_W  MEM/WB result
flush  in  1  synchronous squash (branch/exception)
ex_ready  in  1  EX consumes this cycle
ex_valid  out  1  outputs hold a live instruction
alu_op  out  4  to ALU
crs  out  DATA_W  to ALU, rs operand
alu_in  out  DATA_W  to ALU, second operand
shamt  out  5  to ALU
ex_rt_val  out  DATA_W  forwarded rt value (store data)
ex_rd  out  REG_AW  destination passthrough
ex_reg_write  out  1  write-enable passthrough

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n.
- Reset: every registered output is 0, including ex_valid.
- id_ready is combinational: !ex_valid || ex_ready.
- Accept: id_valid && id_ready && !flush. On the next edge all fields load and ex_valid goes to 1. Latency is 1 cycle.
- Consume without accept: ex_valid && ex_ready && no accept. ex_valid goes to 0 and the data registers hold their stale contents.
- Stall: ex_valid && !ex_ready. All fields hold except for snoop updates (below). id_ready is 0.
- Flush: has priority over accept and stall. Next edge ex_valid=0 and ex_reg_write=0. Any instruction offered in the same cycle is dropped.
- Forward select for an operand with address a:
  - if exm_reg_write && exm_rd==a && a!=0, use exm_value;
  - else if wb_reg_write && wb_rd==a && a!=0, use wb_value;
  - else use the register-file value.
  - EX/MEM beats MEM/WB. Register 0 is never forwarded.
- Operands at capture:
  - crs = fwd(rs).
  - ex_rt_val = fwd(rt).
  - alu_in = id_alu_src ? ext(id_imm) : fwd(rt).
  - ext(): sign- or zero-extends IMM_W to DATA_W per id_imm_sext.
- Snoop during stall: each stalled cycle, the held crs and ex_rt_val re-apply the same forward select using the stored rs/rt addresses. alu_in follows ex_rt_val when the stored alu_src=0. This prevents stale operands after a producer retires during the stall.
- Stored rs_addr, rt_addr and alu_src are internal registers, not ports.
- Stall and flush in the same cycle: flush wins.
- Reset mid-stall: the instruction is lost and ex_valid=0 immediately (asynchronous).

Optional Feature:
FWD_EN
- Defined: forwarding and snoop logic as above.
- Undefined: operands are captured raw from id_rs_val/id_rt_val, there is no snoop during stall, and hazards are the compiler's responsibility (NOP insertion).
- Handshake, flush and immediate logic are identical in both builds.

Decomposition:
- Package cpu_pkg holds:
  - ALU_OP_W=4 and the ALU opcode constants;
  - REG_ZERO=0;
  - DATA_W/REG_AW defaults;
  - an fwd_sel enum {FWD_RF, FWD_EXM, FWD_WB}.
- Sub-module fwd_mux: combinational address compare plus 3:1 select. It is instantiated twice (rs, rt) and reused for the snoop path.

Test Plan:
1. Reset, then id_valid=1, alu_op=2, rs_val=5, rt_val=7, alu_src=0 → next cycle ex_valid=1, crs=5, alu_in=7, id_ready=1.
2. rs_addr=3, exm_reg_write=1, exm_rd=3, exm_value=0xAA, wb_rd=3, wb_value=0xBB → crs=0xAA; repeat with exm_reg_write=0 → crs=0xBB. rs_addr=0 with exm_rd=0 → crs=rs_val.
3. id_imm=0x8000, alu_src=1: sext=1 → alu_in=0xFFFF8000; sext=0 → alu_in=0x00008000.
4. Stall (ex_ready=0) for 3 cycles holding rt_addr=4, alu_src=0; in cycle 2 wb_reg_write=1, wb_rd=4, wb_value=0x1234 → alu_in=ex_rt_val=0x1234 and id_ready=0 throughout; release → ex_valid drops if id_valid=0.
5. flush=1 together with id_valid=1 while stalled → next cycle ex_valid=0, ex_reg_write=0, offered instruction not captured.
6. rst_n low mid-stall → ex_valid=0 and all outputs 0 before the next clk edge.
